// File: rtl/ram_seq_pkg.sv
// Shared types and helpers for the RAM address sequencer.
package ram_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } seq_state_e;

  localparam int DEF_BEAT_BYTES   = 4;
  localparam int DEF_BURST_LENGTH = 16;
  localparam int DEF_PAGE_LOG2    = 16;

  localparam int BURST_BYTES = DEF_BURST_LENGTH * DEF_BEAT_BYTES;
  localparam int PAGE_BYTES  = 2 ** DEF_PAGE_LOG2;

  // Ceiling log2, for elaboration-time widths and masks.
  function automatic int clogb2(input int value);
    int r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r++;
    return r;
  endfunction

endpackage

// File: rtl/ram_seq_offset_counter.sv
// Byte offset within the current page plus the page bit of the ping-pong ring.
module ram_seq_offset_counter
  import ram_seq_pkg::*;
#(
  parameter int PAGE_LOG2  = DEF_PAGE_LOG2,
  parameter int BEAT_BYTES = DEF_BEAT_BYTES,
  parameter int BURST_B    = BURST_BYTES,
  parameter int PAGE_B     = PAGE_BYTES
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 load_i,
  output logic [PAGE_LOG2-1:0] offset_o,
  output logic                 page_o,
  output logic                 last_o,
  output logic                 aligned_o,
  output logic                 aligned_post_o
);

  localparam logic [PAGE_LOG2-1:0] STEP       = PAGE_LOG2'(BEAT_BYTES);
  localparam logic [PAGE_LOG2-1:0] LAST_OFF   = PAGE_LOG2'(PAGE_B - BEAT_BYTES);
  localparam logic [PAGE_LOG2-1:0] BURST_MASK = PAGE_LOG2'((1 << clogb2(BURST_B)) - 1);

  logic [PAGE_LOG2-1:0] offset_q, offset_d;
  logic                 page_q, page_d;

  assign offset_o       = offset_q;
  assign page_o         = page_q;
  assign last_o         = (offset_q == LAST_OFF);
  assign aligned_o      = ((offset_q & BURST_MASK) == '0);
  // Alignment as it will be after this cycle's load, so a stop request sees the load first.
  assign aligned_post_o = ((offset_d & BURST_MASK) == '0);

  always_comb begin
    offset_d = offset_q;
    page_d   = page_q;
    if (clear_i) begin
      offset_d = '0;
      page_d   = 1'b0;
    end else if (load_i) begin
      offset_d = offset_q + STEP;
      if (last_o) page_d = ~page_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      offset_q <= '0;
      page_q   <= 1'b0;
    end else begin
      offset_q <= offset_d;
      page_q   <= page_d;
    end
  end

endmodule

// File: rtl/ram_address_sequencer.sv
// Re-emits the sample stream with ping-pong ring byte addresses, stopping only on burst boundaries.
// Optional SEQ_DROP_COUNT_EN adds a saturating count of beats dropped under back-pressure.
module ram_address_sequencer
  import ram_seq_pkg::*;
#(
  parameter int ADDR_WIDTH       = 32,
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int BEAT_BYTES       = DEF_BEAT_BYTES,
  parameter int BURST_LENGTH     = DEF_BURST_LENGTH,
  parameter int PAGE_LOG2        = DEF_PAGE_LOG2
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        enable,
  input  logic [ADDR_WIDTH-1:0]       base_address,
  input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
  input  logic                        S_AXIS_tvalid,
  output logic                        S_AXIS_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
  output logic                        M_AXIS_tvalid,
  input  logic                        M_AXIS_tready,
  output logic [ADDR_WIDTH-1:0]       address,
  output logic                        page,
  output logic                        page_done,
  output logic                        done_page,
  output logic                        busy,
  output logic [31:0]                 drop_count
);

  seq_state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]       base_q, addr_q;
  logic [AXIS_TDATA_WIDTH-1:0] data_q;
  logic                        vld_q, last_q, beat_page_q, pd_q, dp_q;
  logic                        accept, load, hs, cnt_clear;
  logic [PAGE_LOG2-1:0]        offset;
  logic                        last, aligned, aligned_post;

  ram_seq_offset_counter #(
    .PAGE_LOG2  (PAGE_LOG2),
    .BEAT_BYTES (BEAT_BYTES),
    .BURST_B    (BURST_LENGTH * BEAT_BYTES),
    .PAGE_B     (2 ** PAGE_LOG2)
  ) u_cnt (
    .clk_i          (aclk),
    .rst_i          (areset),
    .clear_i        (cnt_clear),
    .load_i         (load),
    .offset_o       (offset),
    .page_o         (page),
    .last_o         (last),
    .aligned_o      (aligned),
    .aligned_post_o (aligned_post)
  );

  // The source cannot stall: unwanted beats are swallowed rather than back-pressured.
  assign S_AXIS_tready = ~areset;
  assign load          = S_AXIS_tvalid & accept & (~vld_q | M_AXIS_tready);
  assign hs            = vld_q & M_AXIS_tready;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN:     if (!enable) state_d = aligned_post ? IDLE : DRAIN;
      DRAIN:   if (aligned && (!vld_q || M_AXIS_tready)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    accept    = 1'b0;
    cnt_clear = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE:  cnt_clear = enable;
      RUN: begin
        accept = 1'b1;
        busy   = 1'b1;
      end
      // Once the burst is closed no more beats are taken; just wait for the last one to leave.
      DRAIN: begin
        accept = ~aligned;
        busy   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      base_q      <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      vld_q       <= 1'b0;
      last_q      <= 1'b0;
      beat_page_q <= 1'b0;
      pd_q        <= 1'b0;
      dp_q        <= 1'b0;
    end else begin
      if (state_q == IDLE && enable) base_q <= base_address;
      if (load) begin
        data_q      <= S_AXIS_tdata;
        addr_q      <= base_q + ADDR_WIDTH'({page, offset});
        last_q      <= last;
        beat_page_q <= page;
        vld_q       <= 1'b1;
      end else if (hs) begin
        vld_q <= 1'b0;
      end
      pd_q <= hs & last_q;
      if (hs & last_q) dp_q <= beat_page_q;
    end
  end

  assign M_AXIS_tdata  = data_q;
  assign M_AXIS_tvalid = vld_q;
  assign address       = addr_q;
  assign page_done     = pd_q;
  assign done_page     = dp_q;

`ifdef SEQ_DROP_COUNT_EN
  logic        drop;
  logic [31:0] drop_q;

  assign drop = S_AXIS_tvalid & accept & vld_q & ~M_AXIS_tready;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset)                      drop_q <= '0;
    else if (cnt_clear)              drop_q <= '0;
    else if (drop && drop_q != '1)   drop_q <= drop_q + 32'd1;
  end

  assign drop_count = drop_q;
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_ram_address_sequencer.sv
// Randomised/directed bench for ram_address_sequencer against a beat-count reference model.
module tb_ram_address_sequencer;

  localparam int BEAT  = 4;
  localparam int BURST = 16;
  localparam int PAGE  = 128;

  logic        aclk = 1'b0;
  logic        areset, enable, S_AXIS_tvalid, M_AXIS_tready;
  logic [31:0] base_address, S_AXIS_tdata;
  logic        S_AXIS_tready, M_AXIS_tvalid, page, page_done, done_page, busy;
  logic [31:0] M_AXIS_tdata, address, drop_count;

  int checks = 0;
  int errors = 0;

  // Reference model: beats loaded since the last start (m_n) fixes every address and page.
  int          m_mode, m_n, m_oidx;
  logic [31:0] m_base, m_data, m_addr, m_drops, exp_drop;
  logic        m_vld, m_pd, m_dp, m_busy, m_page;

  ram_address_sequencer #(.PAGE_LOG2(7)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .enable        (enable),
    .base_address  (base_address),
    .S_AXIS_tdata  (S_AXIS_tdata),
    .S_AXIS_tvalid (S_AXIS_tvalid),
    .S_AXIS_tready (S_AXIS_tready),
    .M_AXIS_tdata  (M_AXIS_tdata),
    .M_AXIS_tvalid (M_AXIS_tvalid),
    .M_AXIS_tready (M_AXIS_tready),
    .address       (address),
    .page          (page),
    .page_done     (page_done),
    .done_page     (done_page),
    .busy          (busy),
    .drop_count    (drop_count)
  );

  always #5 aclk = ~aclk;

  wire [37:0] st_got = {S_AXIS_tready, M_AXIS_tvalid, busy, page, page_done, done_page, drop_count};
  wire [37:0] st_exp = {1'b1, m_vld, m_busy, m_page, m_pd, m_dp, exp_drop};
  wire [63:0] bt_got = {M_AXIS_tdata, address};
  wire [63:0] bt_exp = {m_data, m_addr};

  // Advance the model by one clock using the inputs currently applied, then step the DUT.
  task automatic tick();
    bit acc, room, ld, dr, hs;
    if (areset) begin
      m_mode = 0; m_n = 0; m_oidx = 0; m_base = 0; m_data = 0; m_addr = 0;
      m_drops = 0; m_vld = 0; m_pd = 0; m_dp = 0;
    end else begin
      acc  = (m_mode == 1) || (m_mode == 2 && (m_n % BURST) != 0);
      room = !m_vld || M_AXIS_tready;
      ld   = S_AXIS_tvalid && acc && room;
      dr   = S_AXIS_tvalid && acc && !room;
      hs   = m_vld && M_AXIS_tready;
      m_pd = hs && ((m_oidx * BEAT) % PAGE == PAGE - BEAT);
      if (m_pd) m_dp = (((m_oidx * BEAT) / PAGE) % 2) == 1;
      if (dr && m_drops != 32'hFFFF_FFFF) m_drops++;
      case (m_mode)
        0: if (enable) begin m_mode = 1; m_base = base_address; m_n = 0; m_drops = 0; end
        1: if (!enable) m_mode = ((m_n + int'(ld)) % BURST == 0) ? 0 : 2;
        default: if ((m_n % BURST) == 0 && room) m_mode = 0;
      endcase
      if (ld) begin
        m_data = S_AXIS_tdata;
        m_addr = m_base + 32'((m_n * BEAT) % (2 * PAGE));
        m_oidx = m_n;
        m_n++;
        m_vld = 1;
      end else if (hs) begin
        m_vld = 0;
      end
    end
    m_busy = (m_mode != 0);
    m_page = (((m_n * BEAT) / PAGE) % 2) == 1;
`ifdef SEQ_DROP_COUNT_EN
    exp_drop = m_drops;
`else
    exp_drop = 32'd0;
`endif
    @(posedge aclk);
    #1;
  endtask

  task automatic to_idle();
    enable = 0; S_AXIS_tvalid = 1; M_AXIS_tready = 1;
    for (int k = 0; k < 80 && m_mode != 0; k++) begin
      S_AXIS_tdata = $urandom;
      tick();
    end
    checks++;
    if (m_mode != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL to_idle timeout: busy=%b model_mode=%0d", busy, m_mode);
    end
    S_AXIS_tvalid = 0;
    tick(); tick();
  endtask

  task automatic test_reset();
    tick(); tick();
    checks++;
    if ({M_AXIS_tvalid, M_AXIS_tdata, address, page, page_done, done_page, busy, drop_count} !== '0) begin
      errors++; $display("FAIL reset_values got v=%b d=%h a=%h busy=%b dc=%0d exp all zero",
                         M_AXIS_tvalid, M_AXIS_tdata, address, busy, drop_count);
    end
    areset = 0;
    tick();
    checks++;
    if (st_got !== st_exp) begin errors++; $display("FAIL reset_release got=%h exp=%h", st_got, st_exp); end
  endtask

  task automatic test_fill();
    int npd = 0;
    base_address = 32'h1000_0000; enable = 1; tick();
    for (int i = 0; i < 40; i++) begin
      S_AXIS_tvalid = 1; S_AXIS_tdata = i; M_AXIS_tready = 1;
      tick();
      checks++;
      if (st_got !== st_exp) begin errors++; $display("FAIL fill_status got=%h exp=%h", st_got, st_exp); end
      if (m_vld) begin
        checks++;
        if (bt_got !== bt_exp) begin errors++; $display("FAIL fill_beat got=%h exp=%h", bt_got, bt_exp); end
      end
      if (page_done) npd++;
    end
    checks++;
    if (npd != 1 || done_page !== 1'b0) begin
      errors++; $display("FAIL fill_page_done got pulses=%0d done_page=%b exp 1 and 0", npd, done_page);
    end
    checks++;
    if (address !== 32'h1000_009C) begin
      errors++; $display("FAIL fill_last_addr got=%h exp=%h", address, 32'h1000_009C);
    end
    to_idle();
  endtask

  task automatic test_drain();
    int nb = 0;
    logic [31:0] last_a = 0;
    base_address = 32'h1000_0000; enable = 1; tick();
    for (int i = 0; i < 46 && !(i > 6 && m_mode == 0); i++) begin
      if (i == 6) enable = 0;
      S_AXIS_tvalid = 1; S_AXIS_tdata = i; M_AXIS_tready = 1;
      tick();
      checks++;
      if (st_got !== st_exp) begin errors++; $display("FAIL drain_status got=%h exp=%h", st_got, st_exp); end
      if (m_vld) begin
        checks++;
        if (bt_got !== bt_exp) begin errors++; $display("FAIL drain_beat got=%h exp=%h", bt_got, bt_exp); end
      end
      if (M_AXIS_tvalid) begin nb++; last_a = address; end
    end
    checks++;
    if (nb != 16 || last_a !== 32'h1000_003C) begin
      errors++; $display("FAIL drain_extent got beats=%0d last=%h exp 16 and 1000003c", nb, last_a);
    end
    S_AXIS_tdata = 32'hDEAD_BEEF; tick();
    checks++;
    if ({busy, M_AXIS_tvalid} !== 2'b00) begin
      errors++; $display("FAIL drain_idle_discard got busy=%b valid=%b exp 0 0", busy, M_AXIS_tvalid);
    end
    to_idle();
  endtask

  task automatic test_backpressure();
    logic [31:0] prev = 0;
    bit have = 0;
    base_address = 32'h1000_0000; enable = 1; tick();
    for (int i = 0; i < 20; i++) begin
      S_AXIS_tvalid = 1; S_AXIS_tdata = $urandom;
      M_AXIS_tready = !(i >= 4 && i < 7);
      tick();
      checks++;
      if (st_got !== st_exp) begin errors++; $display("FAIL bp_status got=%h exp=%h", st_got, st_exp); end
      if (m_vld) begin
        checks++;
        if (bt_got !== bt_exp) begin errors++; $display("FAIL bp_beat got=%h exp=%h", bt_got, bt_exp); end
      end
      if (M_AXIS_tvalid) begin
        if (have && address !== prev) begin
          checks++;
          if (address !== prev + 32'd4) begin
            errors++; $display("FAIL bp_contiguous got=%h exp=%h", address, prev + 32'd4);
          end
        end
        prev = address; have = 1;
      end
    end
    to_idle();
  endtask

  task automatic test_wrap();
    bit pq[$];
    bit dq[$];
    base_address = 32'h1000_0000; enable = 1; tick();
    pq.push_back(page);
    for (int i = 0; i < 65; i++) begin
      S_AXIS_tvalid = 1; S_AXIS_tdata = $urandom; M_AXIS_tready = 1;
      tick();
      checks++;
      if (st_got !== st_exp) begin errors++; $display("FAIL wrap_status got=%h exp=%h", st_got, st_exp); end
      if (m_vld) begin
        checks++;
        if (bt_got !== bt_exp) begin errors++; $display("FAIL wrap_beat got=%h exp=%h", bt_got, bt_exp); end
      end
      if (page !== pq[pq.size()-1]) pq.push_back(page);
      if (page_done) dq.push_back(done_page);
    end
    checks++;
    if (address !== 32'h1000_0000) begin
      errors++; $display("FAIL wrap_beat64_addr got=%h exp=%h", address, 32'h1000_0000);
    end
    checks++;
    if (pq.size() != 3 || pq[0] != 0 || pq[1] != 1 || pq[2] != 0) begin
      errors++; $display("FAIL wrap_page_seq got len=%0d exp 0,1,0", pq.size());
    end
    checks++;
    if (dq.size() != 2 || dq[0] != 0 || dq[1] != 1) begin
      errors++; $display("FAIL wrap_done_seq got len=%0d exp 0,1", dq.size());
    end
    to_idle();
  endtask

  task automatic test_async_reset();
    base_address = 32'h1000_0000; enable = 1; tick();
    for (int i = 0; i < 7; i++) begin
      S_AXIS_tvalid = 1; S_AXIS_tdata = 32'hA000 + i; M_AXIS_tready = 1;
      tick();
    end
    areset = 1;
    #2;
    checks++;
    if ({M_AXIS_tvalid, M_AXIS_tdata, address, page, page_done, busy} !== '0) begin
      errors++; $display("FAIL async_reset got v=%b d=%h a=%h page=%b busy=%b exp zeros",
                         M_AXIS_tvalid, M_AXIS_tdata, address, page, busy);
    end
    tick(); tick();
    areset = 0; tick();
    for (int i = 0; i < 5; i++) begin
      S_AXIS_tvalid = 1; S_AXIS_tdata = $urandom;
      tick();
      checks++;
      if (st_got !== st_exp) begin errors++; $display("FAIL rst_resume_status got=%h exp=%h", st_got, st_exp); end
      if (m_vld) begin
        checks++;
        if (bt_got !== bt_exp) begin errors++; $display("FAIL rst_resume_beat got=%h exp=%h", bt_got, bt_exp); end
      end
      if (i == 0) begin
        checks++;
        if (address !== 32'h1000_0000 || page !== 1'b0) begin
          errors++; $display("FAIL rst_restart got a=%h page=%b exp 10000000 0", address, page);
        end
      end
    end
    to_idle();
  endtask

  task automatic test_base_change();
    base_address = 32'h2000_0000; enable = 1; tick();
    for (int i = 0; i < 10; i++) begin
      if (i == 5) base_address = 32'h3000_0000;
      S_AXIS_tvalid = 1; S_AXIS_tdata = $urandom; M_AXIS_tready = 1;
      tick();
      checks++;
      if (st_got !== st_exp) begin errors++; $display("FAIL base_status got=%h exp=%h", st_got, st_exp); end
      if (m_vld) begin
        checks++;
        if (bt_got !== bt_exp) begin errors++; $display("FAIL base_beat got=%h exp=%h", bt_got, bt_exp); end
      end
    end
    checks++;
    if (address !== 32'h2000_0024) begin
      errors++; $display("FAIL base_held got=%h exp=%h", address, 32'h2000_0024);
    end
    to_idle();
    enable = 1; tick();
    S_AXIS_tvalid = 1; tick();
    checks++;
    if (address !== 32'h3000_0000) begin
      errors++; $display("FAIL base_relatch got=%h exp=%h", address, 32'h3000_0000);
    end
    to_idle();
  endtask

  task automatic test_random();
    base_address = $urandom & 32'hFFFF_FF00; enable = 1;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 24) == 0) enable = ~enable;
      if ($urandom_range(0, 49) == 0) base_address = $urandom & 32'hFFFF_FF00;
      S_AXIS_tvalid = ($urandom_range(0, 3) != 0);
      S_AXIS_tdata  = $urandom;
      M_AXIS_tready = ($urandom_range(0, 2) != 0);
      tick();
      checks++;
      if (st_got !== st_exp) begin errors++; $display("FAIL rand_status t=%0t got=%h exp=%h", $time, st_got, st_exp); end
      if (m_vld) begin
        checks++;
        if (bt_got !== bt_exp) begin errors++; $display("FAIL rand_beat t=%0t got=%h exp=%h", $time, bt_got, bt_exp); end
      end
    end
  endtask

  initial begin
    areset = 1; enable = 0; base_address = 0; S_AXIS_tdata = 0; S_AXIS_tvalid = 0; M_AXIS_tready = 1;
    test_reset();
    test_fill();
    test_drain();
    test_backpressure();
    test_wrap();
    test_async_reset();
    test_base_change();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
